// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART: TX and RX share one 16x oversampling tick.
// RX uses a 2-flop synchroniser and a 3-sample majority vote per bit.
`timescale 1ns/1ps
module uart_core_cfg #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------- tick generator ----------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_s;

  // free-running oversampling divider
  always_comb begin
    tick_s     = (tick_cnt_q == TW'(DIV - 1));
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // ---------------- transmitter ----------------
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_sub_q, tx_sub_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_bit_end_s;

  // TX next state; the line output is registered so it lags the state by one cycle
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_sub_d     = tx_sub_q;
    tx_bit_d     = tx_bit_q;
    tx_sh_d      = tx_sh_q;
    tx_par_d     = tx_par_q;
    tx_busy_d    = tx_busy_q;
    tx_done_d    = 1'b0;
    tx_d         = 1'b1;
    tx_bit_end_s = tick_s && (tx_sub_q == 4'd15);
    if (tick_s && (tx_state_q != S_IDLE)) tx_sub_d = tx_sub_q + 4'd1;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          tx_sh_d    = tx_data;
          tx_par_d   = par_bit(tx_data);
          tx_sub_d   = 4'd0;
          tx_bit_d   = 4'd0;
          tx_busy_d  = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tx_bit_end_s) begin
          tx_bit_d   = 4'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = tx_sh_q[0];
        if (tx_bit_end_s) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == 4'(DATA_BITS - 1)) begin
            tx_bit_d   = 4'd0;
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        tx_d = tx_par_q;
        if (tx_bit_end_s) begin
          tx_bit_d   = 4'd0;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tx_bit_end_s) begin
          if (tx_bit_q == 4'(STOP_BITS - 1)) begin
            tx_done_d  = 1'b1;
            tx_busy_d  = 1'b0;
            tx_state_d = S_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_busy_d  = 1'b0;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_sub_q   <= 4'd0;
      tx_bit_q   <= 4'd0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // ---------------- receiver ----------------
  state_e               rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [3:0]           rx_sub_q, rx_sub_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_s7_q, rx_s7_d;
  logic                 rx_s8_q, rx_s8_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_pe_q, rx_pe_d;
  logic                 rx_fe_q, rx_fe_d;
  logic                 rx_samp_end_s, rx_bit_end_s, rx_maj_s;

  // RX next state; every bit is decided on sub-tick 9 from samples 7, 8 and 9
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    rx_sub_d      = rx_sub_q;
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_s7_d       = rx_s7_q;
    rx_s8_d       = rx_s8_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_pe_d       = 1'b0;
    rx_fe_d       = 1'b0;
    rx_samp_end_s = tick_s && (rx_sub_q == 4'd9);
    rx_bit_end_s  = tick_s && (rx_sub_q == 4'd15);
    rx_maj_s      = maj3(rx_s7_q, rx_s8_q, rx_s_q);
    if (tick_s && (rx_state_q != S_IDLE)) begin
      rx_sub_d = rx_sub_q + 4'd1;
      if (rx_sub_q == 4'd7) rx_s7_d = rx_s_q;
      else if (rx_sub_q == 4'd8) rx_s8_d = rx_s_q;
      else rx_s7_d = rx_s7_q;
    end
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          rx_sub_d   = 4'd0;
          rx_perr_d  = 1'b0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_samp_end_s && rx_maj_s) begin
          rx_state_d = S_IDLE;
        end else if (rx_bit_end_s) begin
          rx_bit_d   = 4'd0;
          rx_state_d = S_DATA;
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (rx_samp_end_s) rx_sh_d = {rx_maj_s, rx_sh_q[DATA_BITS-1:1]};
        else               rx_sh_d = rx_sh_q;
        if (rx_bit_end_s) begin
          if (rx_bit_q == 4'(DATA_BITS - 1)) begin
            rx_bit_d   = 4'd0;
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (rx_samp_end_s) rx_perr_d = (rx_maj_s != par_bit(rx_sh_q));
        else               rx_perr_d = rx_perr_q;
        if (rx_bit_end_s) rx_state_d = S_STOP;
        else              rx_state_d = S_PARITY;
      end
      S_STOP: begin
        // leave immediately so a start edge right after this stop sample is caught
        if (rx_samp_end_s) begin
          if (rx_maj_s) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            rx_pe_d    = rx_perr_q;
          end else begin
            rx_fe_d = 1'b1;
          end
          rx_state_d = S_IDLE;
        end else begin
          rx_state_d = S_STOP;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state register and synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_sub_q   <= 4'd0;
      rx_bit_q   <= 4'd0;
      rx_sh_q    <= '0;
      rx_s7_q    <= 1'b1;
      rx_s8_q    <= 1'b1;
      rx_perr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s7_q    <= rx_s7_d;
      rx_s8_q    <= rx_s8_d;
      rx_perr_q  <= rx_perr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_frame_err  = rx_fe_q;

endmodule
